// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the seven-segment read-back path:
//   - SEG_CODE[0..9] : active-low {g,f,e,d,c,b,a} patterns for the digits 0..9
//   - SEG_BLANK      : all segments off
//   - digit_t        : packed {err, blank, value[3:0]} result of an inverse decode
//   - out_state_e    : state of the frame output buffer
//   - seg_decode()   : inverse mapping from a segment pattern to a digit_t
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_CODE [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef struct packed {
    logic       err;
    logic       blank;
    logic [3:0] value;
  } digit_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Anything that is neither a digit nor blank is reported as value F with err.
  function automatic digit_t seg_decode(input logic [6:0] seg);
    digit_t d;
    d = '{err: 1'b1, blank: 1'b0, value: 4'hF};
    if (seg == SEG_BLANK) begin
      d = '{err: 1'b0, blank: 1'b1, value: 4'h0};
    end else begin
      for (int i = 0; i < 10; i++) begin
        if (seg == SEG_CODE[i]) d = '{err: 1'b0, blank: 1'b0, value: 4'(i)};
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/seg7_stable_filter.sv
// seg7_stable_filter
// Synchronizes the display lines and raises a one-cycle strobe once the
// combined {an,seg} word has been identical for STABLE_CYCLES samples.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_seg, i_an    : raw active-low segment / digit-enable lines
//   o_seg, o_an    : synchronized lines (valid to use on the strobe cycle)
//   o_strobe       : one pulse per stable run of the synchronized lines
module seg7_stable_filter #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            i_seg,
  input  logic [NUM_DIGITS-1:0] i_an,
  output logic [6:0]            o_seg,
  output logic [NUM_DIGITS-1:0] o_an,
  output logic                  o_strobe
);

  localparam int W = NUM_DIGITS + 7;
  localparam logic [7:0] CNT_SAT  = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_FIRE = 8'(STABLE_CYCLES - 2);

  logic [W-1:0] r_sync1, r_sync2, r_prev;
  logic [7:0]   r_stab_cnt;
  logic         w_equal;

  assign w_equal = (r_sync2 == r_prev);

  // NOTE: every flop in a clocked block uses <= so all of them sample the
  // pre-edge values together; = here would collapse the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= '1;
      r_sync2    <= '1;
      r_prev     <= '1;
      r_stab_cnt <= '0;
    end else begin
      r_sync1 <= {i_an, i_seg};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (!w_equal)                r_stab_cnt <= '0;
      else if (r_stab_cnt != CNT_SAT) r_stab_cnt <= r_stab_cnt + 8'd1;
    end
  end

  // Fires in the cycle whose edge takes stab_cnt to STABLE_CYCLES-1; the
  // counter then runs on to saturation, so a held pattern fires only once.
  assign o_strobe = w_equal && (r_stab_cnt == CNT_FIRE);
  assign o_seg    = r_sync2[6:0];
  assign o_an     = r_sync2[W-1:7];

endmodule

// File: rtl/seg7_readback.sv
// seg7_readback
// Reads back a common-anode multiplexed seven-segment display and presents
// each complete multi-digit frame on a valid/ready interface.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   seg_in       : {g,f,e,d,c,b,a}, active-low
//   an_in        : digit enables, active-low, one-hot-low when driven
//   frame_data   : digit k value at [4k+3:4k]
//   frame_blank  : digit k was dark
//   frame_err    : digit k was not a legal pattern
//   frame_valid  : frame held until frame_ready
//   frame_ready  : consumer accept
//   overrun      : one-cycle pulse when a completed frame is dropped
module seg7_readback
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] frame_data,
  output logic [NUM_DIGITS-1:0]   frame_blank,
  output logic [NUM_DIGITS-1:0]   frame_err,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    overrun
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [6:0]              w_seg;
  logic [NUM_DIGITS-1:0]   w_an;
  logic                    w_strobe;

  seg7_stable_filter #(
    .NUM_DIGITS   (NUM_DIGITS),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_seg   (seg_in),
    .i_an    (an_in),
    .o_seg   (w_seg),
    .o_an    (w_an),
    .o_strobe(w_strobe)
  );

  // Capture qualification: exactly one enable low.
  logic [3:0]       w_low_cnt;
  logic [IDX_W-1:0] w_idx;
  logic             w_capture;
  digit_t           w_dec;

  // NOTE: every signal driven in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_low_cnt = '0;
    w_idx     = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (!w_an[k]) begin
        w_low_cnt = w_low_cnt + 4'd1;
        w_idx     = IDX_W'(k);
      end
    end
  end

  assign w_capture = w_strobe && (w_low_cnt == 4'd1);
  assign w_dec     = seg_decode(w_seg);

  // Collect buffer and seen mask.
  digit_t                r_col [NUM_DIGITS];
  digit_t                w_col_next [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] r_seen, w_seen_next;
  logic                  w_transfer;

  always_comb begin
    w_col_next  = r_col;
    w_seen_next = r_seen;
    if (w_capture) begin
      w_col_next[w_idx]  = w_dec;
      w_seen_next[w_idx] = 1'b1;
    end
  end

  assign w_transfer = w_capture && (&w_seen_next);

  // NOTE: the collect buffer is a handful of flops, so it takes the async
  // reset; a real RAM would be left unreset and guarded by the seen mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_DIGITS; k++) r_col[k] <= '0;
      r_seen <= '0;
    end else begin
      r_col  <= w_col_next;
      r_seen <= w_transfer ? '0 : w_seen_next;
    end
  end

  // Output buffer state machine.
  out_state_e r_state, w_state_next;
  logic       w_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_EMPTY: if (w_transfer) w_state_next = ST_FULL;
      ST_FULL:  if (!w_transfer && frame_ready) w_state_next = ST_EMPTY;
      default:  w_state_next = ST_EMPTY;
    endcase
  end

  always_comb begin
    frame_valid = (r_state == ST_FULL);
  end

  // A new frame lands only if the buffer is free or being emptied this cycle.
  assign w_load = w_transfer && ((r_state == ST_EMPTY) || frame_ready);

  logic [4*NUM_DIGITS-1:0] r_data;
  logic [NUM_DIGITS-1:0]   r_blank, r_err;
  logic                    r_overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data    <= '0;
      r_blank   <= '0;
      r_err     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_transfer && (r_state == ST_FULL) && !frame_ready;
      if (w_load) begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
          r_data[4*k +: 4] <= w_col_next[k].value;
          r_blank[k]       <= w_col_next[k].blank;
          r_err[k]         <= w_col_next[k].err;
        end
      end
    end
  end

  assign frame_data  = r_data;
  assign frame_blank = r_blank;
  assign frame_err   = r_err;
  assign overrun     = r_overrun;

endmodule

// File: doc/seg7_readback.md
# seg7_readback

Sequential read-back monitor for the common-anode multiplexed seven-segment display path. It samples the active-low segment and digit-enable lines that feed the display and filters out scan transitions. Each stable digit pattern is inverse-mapped back to a 4-bit value, and the digits are assembled into a complete multi-digit frame. The frame is presented on a valid/ready interface so that self-check logic or a host register block can confirm what the display is actually showing.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits; range 1..8.
- STABLE_CYCLES, 16: consecutive identical samples required before a digit is captured; range 2..255.
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  one clock; reset is asynchronous, active-low.
- seg_in  in  7  segment lines {g,f,e,d,c,b,a}, active-low (0 = lit).
- an_in  in  NUM_DIGITS  digit enables, active-low; exactly one bit is low when a digit is being driven.
- frame_data  out  4*NUM_DIGITS  digit k value at bits [4k+3:4k].
- frame_blank  out  NUM_DIGITS  bit k set: digit k was all-off (7'b1111111).
- frame_err  out  NUM_DIGITS  bit k set: digit k pattern was not a legal code.
- frame_valid  out  1  frame is available; held until accepted.
- frame_ready  in  1  consumer accepts the frame when high with frame_valid.
- overrun  out  1  one-cycle pulse: a completed frame was dropped.

## Operation
- Synchronizer: two flops on seg_in and an_in. Both flops reset to all-ones (display dark, no digit selected).
- Stability filter:
  - stab_cnt compares the synchronized {an,seg} with the previous synchronized sample.
  - Equal: stab_cnt increments, saturating at STABLE_CYCLES.
  - Different: stab_cnt clears to 0.
  - A capture strobe fires exactly once, on the cycle stab_cnt becomes STABLE_CYCLES-1 (that is, STABLE_CYCLES equal samples).
- Capture qualification:
  - The strobe is ignored unless the synchronized an is one-hot-low.
  - Zero-hot or multi-hot an produces no capture and no error.
- Pattern decode (strobe cycle):
  - Codes 0..9 are 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, giving values 0..9.
  - 1111111 gives value 0 with blank=1.
  - Any other pattern gives value 4'hF with err=1.
- Assembly:
  - Decoded value, blank and err are written into slot k of a collect buffer, and seen[k] is set.
  - Recapturing an already-seen digit overwrites its slot.
  - When seen becomes all-ones, the collect buffer is transferred to the output registers and seen is cleared in the same cycle.
- Output state machine:
  - EMPTY -> FULL on transfer. frame_valid=1 in FULL.
  - FULL -> EMPTY on frame_valid && frame_ready with no simultaneous transfer.
  - Transfer and accept in the same cycle: the new frame loads and the machine stays FULL.
  - Transfer while FULL and not accepted: the new frame is discarded, overrun pulses for 1 cycle, and the held frame is unchanged.
- Output registers change only on a transfer; they are stable while frame_valid=1.

## Timing
- Reset values: frame_data=0, frame_blank=0, frame_err=0, frame_valid=0, overrun=0. Internal reset: stab_cnt=0, seen=0, collect buffer=0, state EMPTY.
- Deassertion of rst_n mid-frame discards the partial frame; collection restarts from seen=0.
- Pin change to capture strobe: 2 (sync) + STABLE_CYCLES-1 cycles once the pins hold steady.
- Capture strobe to seen update: 1 cycle.
- Final digit strobe to frame_valid high: 1 cycle.
- frame_ready to frame_valid low: frame_valid falls the cycle after the handshake cycle.
- Glitches shorter than STABLE_CYCLES samples never capture.
- A held digit captures once only; it recaptures only after the lines change and stabilize again.

## Structure
- Shared package seg7_pkg holds:
  - the ten SEG_CODE constants and SEG_BLANK (7'b1111111);
  - an inverse-decode function returning {err, blank, value[3:0]};
  - the output-state enum.
- The decoder block and its bench use the same package constants.
- Sub-module seg7_stable_filter holds the two-flop synchronizer, the previous-sample register, stab_cnt and strobe generation. It outputs the synchronized {an,seg} plus the strobe.
- The top level holds qualification, decode, the collect buffer, seen, and the output FSM.

## Test plan
All scenarios use STABLE_CYCLES=4 and NUM_DIGITS=4 unless stated otherwise.
- Scan digits 0..3 with patterns for 1,2,3,4 (1111001, 0100100, 0110000, 0011001), 8 cycles each, frame_ready=1 -> frame_valid pulses with frame_data=16'h4321, blank=0, err=0.
- Digit 2 driven 1111111 and digit 3 driven 0101010, the rest legal 0 -> frame_data=16'hF000, frame_blank=4'b0100, frame_err=4'b1000.
- 2-cycle glitch on seg_in during a hold -> no extra capture. With pins held 40 cycles -> exactly one capture.
- frame_ready=0 across two full scans -> first frame held unchanged, overrun pulses once at the second completion. frame_ready=1 then empties the output within 1 cycle.
- Second frame completes on the same cycle as frame_ready=1 -> frame_valid stays 1, new data is visible next cycle, overrun=0.
- rst_n pulsed low after 2 of 4 digits -> all outputs 0 immediately. The next full scan yields a frame with no stale digits; an_in=4'b0011 (multi-hot) is never captured.
